jelly_img_alpha_fade_ctl: RTL and testbench

Frame-synchronous fade sequencer that drives the param_alpha input of the image alpha-blend core. It watches the same image control stream the blend core consumes and steps alpha from a start value toward an end value, one step every N frames. Alpha changes only at a frame start, so no frame is ever blended with two alpha values. Typical uses are cross-fades and fade-in/fade-out between two video sources.

---
 rtl/jelly_img_alpha_fade_ctl.sv | 174 +++++++++++++++++
 tb/tb_jelly_img_alpha_fade_ctl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_img_alpha_fade_ctl.sv
// Frame-synchronous alpha fade sequencer.
// Watches the image control stream that also feeds the alpha-blend core and
// steps m_alpha from a start value toward an end value, one step every
// ctl_interval frames. Alpha only ever changes at a frame start, so each frame
// is blended with a single alpha value.

module jelly_img_alpha_fade_ctl #(
   parameter int                      ALPHA_WIDTH = 8,
   parameter int                      FRAME_WIDTH = 16,
   parameter int                      USE_VALID   = 0,
   parameter logic [ALPHA_WIDTH-1:0]  INIT_ALPHA  = '0
) (
   input  logic                    reset_n,
   input  logic                    clk,
   input  logic                    cke,

   input  logic                    s_img_line_first,
   input  logic                    s_img_pixel_first,
   input  logic                    s_img_de,
   input  logic                    s_img_valid,

   input  logic                    ctl_start,
   input  logic                    ctl_abort,
   input  logic [ALPHA_WIDTH-1:0]  ctl_alpha_start,
   input  logic [ALPHA_WIDTH-1:0]  ctl_alpha_end,
   input  logic [ALPHA_WIDTH-1:0]  ctl_alpha_step,
   input  logic [FRAME_WIDTH-1:0]  ctl_interval,

   output logic [ALPHA_WIDTH-1:0]  m_alpha,
   output logic                    busy,
   output logic                    done,
   output logic [FRAME_WIDTH-1:0]  frame_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN
   } state_t;

   state_t                  state,        state_next;
   logic [ALPHA_WIDTH-1:0]  alpha_next;
   logic                    busy_next;
   logic                    done_next;
   logic [FRAME_WIDTH-1:0]  count_next;

   logic [ALPHA_WIDTH-1:0]  start_q,      start_next;
   logic [ALPHA_WIDTH-1:0]  end_q,        end_next;
   logic [ALPHA_WIDTH-1:0]  step_q,       step_next;
   logic [FRAME_WIDTH-1:0]  interval_q,   interval_next;
   logic [FRAME_WIDTH-1:0]  hold_q,       hold_next;

   logic                    frame_start;
   logic                    valid_ok;
   logic [ALPHA_WIDTH:0]    up_sum;
   logic [ALPHA_WIDTH-1:0]  down_gap;
   logic [ALPHA_WIDTH-1:0]  stepped_alpha;

   // Frame start: first pixel of first line, only while the stream is enabled
   always_comb begin
      valid_ok    = (USE_VALID != 0) ? s_img_valid : 1'b1;
      frame_start = cke & s_img_de & s_img_line_first & s_img_pixel_first & valid_ok;
   end

   // Next alpha after one step, saturating at the end value in either direction
   always_comb begin
      up_sum        = {1'b0, m_alpha} + {1'b0, step_q};
      down_gap      = m_alpha - end_q;
      stepped_alpha = end_q;
      if (step_q == '0) begin
         stepped_alpha = end_q;
      end
      else if (m_alpha < end_q) begin
         stepped_alpha = (up_sum > {1'b0, end_q}) ? end_q : up_sum[ALPHA_WIDTH-1:0];
      end
      else if (m_alpha > end_q) begin
         stepped_alpha = (down_gap <= step_q) ? end_q : (m_alpha - step_q);
      end
   end

   // Sequencer next-state and next-output logic; abort overrides everything
   always_comb begin
      state_next    = state;
      alpha_next    = m_alpha;
      busy_next     = busy;
      done_next     = 1'b0;
      count_next    = frame_count;
      start_next    = start_q;
      end_next      = end_q;
      step_next     = step_q;
      interval_next = interval_q;
      hold_next     = hold_q;

      if (ctl_abort) begin
         state_next = ST_IDLE;
         busy_next  = 1'b0;
      end
      else begin
         case (state)
            ST_IDLE: begin
               if (ctl_start) begin
                  start_next    = ctl_alpha_start;
                  end_next      = ctl_alpha_end;
                  step_next     = ctl_alpha_step;
                  interval_next = (ctl_interval == '0) ? FRAME_WIDTH'(1) : ctl_interval;
                  state_next    = ST_ARM;
                  busy_next     = 1'b1;
               end
            end

            ST_ARM: begin
               if (frame_start) begin
                  alpha_next = start_q;
                  hold_next  = interval_q;
                  count_next = '0;
                  state_next = ST_RUN;
               end
            end

            ST_RUN: begin
               if (frame_start) begin
                  count_next = frame_count + FRAME_WIDTH'(1);
                  if (m_alpha == end_q) begin
                     state_next = ST_IDLE;
                     busy_next  = 1'b0;
                     done_next  = 1'b1;
                  end
                  else if (hold_q > FRAME_WIDTH'(1)) begin
                     hold_next = hold_q - FRAME_WIDTH'(1);
                  end
                  else begin
                     hold_next  = interval_q;
                     alpha_next = stepped_alpha;
                  end
               end
            end

            default: begin
               state_next = ST_IDLE;
               busy_next  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         m_alpha     <= INIT_ALPHA;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_count <= '0;
         start_q     <= '0;
         end_q       <= '0;
         step_q      <= '0;
         interval_q  <= '0;
         hold_q      <= '0;
      end
      else begin
         state       <= state_next;
         m_alpha     <= alpha_next;
         busy        <= busy_next;
         done        <= done_next;
         frame_count <= count_next;
         start_q     <= start_next;
         end_q       <= end_next;
         step_q      <= step_next;
         interval_q  <= interval_next;
         hold_q      <= hold_next;
      end
   end

endmodule

// File: tb/tb_jelly_img_alpha_fade_ctl.sv
// Testbench for jelly_img_alpha_fade_ctl.
// A driver issues directed and random cycles and pushes the expected outputs
// from a schedule-based reference model into a queue; a monitor pops and
// compares one entry after every clock edge.

module tb_jelly_img_alpha_fade_ctl;

   localparam int ALPHA_WIDTH = 8;
   localparam int FRAME_WIDTH = 16;
   localparam int INIT_VALUE  = 0;

   logic                    reset_n;
   logic                    clk;
   logic                    cke;
   logic                    s_img_line_first;
   logic                    s_img_pixel_first;
   logic                    s_img_de;
   logic                    s_img_valid;
   logic                    ctl_start;
   logic                    ctl_abort;
   logic [ALPHA_WIDTH-1:0]  ctl_alpha_start;
   logic [ALPHA_WIDTH-1:0]  ctl_alpha_end;
   logic [ALPHA_WIDTH-1:0]  ctl_alpha_step;
   logic [FRAME_WIDTH-1:0]  ctl_interval;
   logic [ALPHA_WIDTH-1:0]  m_alpha;
   logic                    busy;
   logic                    done;
   logic [FRAME_WIDTH-1:0]  frame_count;

   jelly_img_alpha_fade_ctl #(
      .ALPHA_WIDTH (ALPHA_WIDTH),
      .FRAME_WIDTH (FRAME_WIDTH),
      .USE_VALID   (1),
      .INIT_ALPHA  (ALPHA_WIDTH'(INIT_VALUE))
   ) dut (
      .reset_n           (reset_n),
      .clk               (clk),
      .cke               (cke),
      .s_img_line_first  (s_img_line_first),
      .s_img_pixel_first (s_img_pixel_first),
      .s_img_de          (s_img_de),
      .s_img_valid       (s_img_valid),
      .ctl_start         (ctl_start),
      .ctl_abort         (ctl_abort),
      .ctl_alpha_start   (ctl_alpha_start),
      .ctl_alpha_end     (ctl_alpha_end),
      .ctl_alpha_step    (ctl_alpha_step),
      .ctl_interval      (ctl_interval),
      .m_alpha           (m_alpha),
      .busy              (busy),
      .done              (done),
      .frame_count       (frame_count)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int alpha;
      bit busy;
      bit done;
      int count;
   } expect_t;

   expect_t expect_q[$];
   expect_t mon_entry;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a fade is a precomputed list of per-frame alpha values,
   // terminated by -1 for the frame on which done is reported.
   int sched[$];
   bit mdl_busy;
   bit mdl_armed;
   int mdl_alpha;
   int mdl_count;

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic void build_schedule(input int a_s, input int a_e, input int a_st, input int iv);
      int ivl;
      int a;
      ivl = (iv == 0) ? 1 : iv;
      a   = a_s;
      sched.delete();
      while (a != a_e) begin
         for (int k = 0; k < ivl; k++) sched.push_back(a);
         if (a_st == 0)     a = a_e;
         else if (a < a_e)  a = (a + a_st > a_e) ? a_e : a + a_st;
         else               a = (a - a_st < a_e) ? a_e : a - a_st;
      end
      sched.push_back(a_e);
      sched.push_back(-1);
   endfunction

   function automatic void model_reset();
      sched.delete();
      mdl_busy  = 1'b0;
      mdl_armed = 1'b0;
      mdl_alpha = INIT_VALUE;
      mdl_count = 0;
   endfunction

   // Drive one cycle of inputs at the falling edge and record the outputs the
   // model predicts after the following rising edge
   task automatic apply_stimulus(input bit st, input bit ab, input int a_s, input int a_e,
                                 input int a_st, input int iv, input bit [3:0] taps, input bit ck);
      bit      fs;
      bit      done_e;
      int      v;
      expect_t e;
      @(negedge clk);
      ctl_start         = st;
      ctl_abort         = ab;
      ctl_alpha_start   = ALPHA_WIDTH'(a_s);
      ctl_alpha_end     = ALPHA_WIDTH'(a_e);
      ctl_alpha_step    = ALPHA_WIDTH'(a_st);
      ctl_interval      = FRAME_WIDTH'(iv);
      s_img_de          = taps[3];
      s_img_line_first  = taps[2];
      s_img_pixel_first = taps[1];
      s_img_valid       = taps[0];
      cke               = ck;

      fs     = ck & (taps == 4'b1111);
      done_e = 1'b0;
      if (ab) begin
         mdl_busy  = 1'b0;
         mdl_armed = 1'b0;
         sched.delete();
      end
      else if (!mdl_busy) begin
         if (st) begin
            build_schedule(a_s, a_e, a_st, iv);
            mdl_busy  = 1'b1;
            mdl_armed = 1'b1;
         end
      end
      else if (fs) begin
         v = sched.pop_front();
         if (mdl_armed) begin
            mdl_alpha = v;
            mdl_count = 0;
            mdl_armed = 1'b0;
         end
         else begin
            mdl_count++;
            if (v < 0) begin
               mdl_busy = 1'b0;
               done_e   = 1'b1;
            end
            else begin
               mdl_alpha = v;
            end
         end
      end
      e.alpha = mdl_alpha;
      e.busy  = mdl_busy;
      e.done  = done_e;
      e.count = mdl_count % (1 << FRAME_WIDTH);
      expect_q.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++)
         apply_stimulus(0, 0, 0, 0, 0, 0, {1'($urandom), 1'($urandom), 1'b0, 1'($urandom)}, 1);
   endtask

   task automatic start_fade(input int a_s, input int a_e, input int a_st, input int iv);
      apply_stimulus(1, 0, a_s, a_e, a_st, iv, 4'b0000, 1);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(0, 0, 0, 0, 0, 0, 4'b1111, 1);
         idle_cycles(2);
      end
   endtask

   // Asynchronous reset between clock edges, checked before any edge arrives
   task automatic async_reset_check();
      @(negedge clk);
      ctl_start = 1'b0;
      ctl_abort = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check_output("async_reset_alpha", int'(m_alpha), INIT_VALUE);
      check_output("async_reset_busy", int'(busy), 0);
      check_output("async_reset_done", int'(done), 0);
      check_output("async_reset_count", int'(frame_count), 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // Monitor: compare the DUT against the oldest pending expectation
   always @(posedge clk) begin
      #1;
      if (expect_q.size() > 0) begin
         mon_entry = expect_q.pop_front();
         check_output("m_alpha", int'(m_alpha), mon_entry.alpha);
         check_output("busy", int'(busy), int'(mon_entry.busy));
         check_output("done", int'(done), int'(mon_entry.done));
         check_output("frame_count", int'(frame_count), mon_entry.count);
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      reset_n           = 1'b0;
      cke               = 1'b1;
      s_img_line_first  = 1'b0;
      s_img_pixel_first = 1'b0;
      s_img_de          = 1'b0;
      s_img_valid       = 1'b0;
      ctl_start         = 1'b0;
      ctl_abort         = 1'b0;
      ctl_alpha_start   = '0;
      ctl_alpha_end     = '0;
      ctl_alpha_step    = '0;
      ctl_interval      = '0;
      model_reset();
      #1;
      check_output("reset_alpha", int'(m_alpha), INIT_VALUE);
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_done", int'(done), 0);
      check_output("reset_count", int'(frame_count), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle_cycles(3);

      // Up fade 0 -> 255 step 64
      start_fade(0, 255, 64, 1);
      frames(7);
      idle_cycles(3);

      // Down fade 200 -> 10 step 100, every 2 frames
      start_fade(200, 10, 100, 2);
      frames(8);

      // Jump to end with interval 0 treated as 1
      start_fade(30, 220, 0, 0);
      frames(4);

      // Abort mid-fade at 128, then simultaneous start and abort
      start_fade(0, 255, 64, 1);
      frames(3);
      apply_stimulus(0, 1, 0, 0, 0, 0, 4'b0000, 1);
      idle_cycles(2);
      frames(1);
      apply_stimulus(1, 1, 40, 90, 5, 1, 4'b0000, 1);
      idle_cycles(1);
      frames(2);

      // fs together with start, gated fs, and start while busy
      apply_stimulus(1, 0, 50, 100, 10, 1, 4'b1111, 1);
      idle_cycles(1);
      frames(2);
      apply_stimulus(0, 0, 0, 0, 0, 0, 4'b1111, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 4'b1110, 1);
      apply_stimulus(1, 0, 0, 0, 0, 0, 4'b0000, 1);
      frames(7);

      // Saturation without wrap or underflow, and start equal to end
      start_fade(250, 255, 10, 1);
      frames(4);
      start_fade(5, 0, 10, 1);
      frames(4);
      start_fade(77, 77, 3, 2);
      frames(3);

      // Asynchronous reset mid-fade
      start_fade(0, 255, 64, 1);
      frames(3);
      async_reset_check();
      idle_cycles(2);
      frames(2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int a_s;
         int a_e;
         a_s = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
         a_e = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
         apply_stimulus($urandom_range(0, 19) == 0,
                        $urandom_range(0, 149) == 0,
                        a_s, a_e,
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80),
                        $urandom_range(0, 3),
                        {1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                         1'($urandom_range(0, 7) != 0)},
                        $urandom_range(0, 7) != 0);
      end

      idle_cycles(1);
      repeat (3) @(negedge clk);
      check_output("queue_drained", expect_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
